lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/cpu_pkg.sv | 17 +
 rtl/lsu_addr_chk.sv | 26 ++
 rtl/scdatamem.sv | 63 ++++++
 rtl/lsu_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: access-size encodings, LSU FSM state type, data-memory address width.
package cpu_pkg;

  localparam int DMEM_AW = 13;

  localparam logic [1:0] SZ_ILL  = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/lsu_addr_chk.sv
// Combinational access-error decode: out-of-range address or illegal size, plus
// misalignment when LSU_ALIGN_CHECK_EN is defined.
module lsu_addr_chk
  import cpu_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        err
);

  logic w_misalign;
  logic w_unused_lo;

  // Low address bits only matter to the memory, not to the range check.
  assign w_unused_lo = ^addr[DMEM_AW-1:0];

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misalign = ((size == SZ_HALF) && addr[0]) ||
                      ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign err = (addr[31:DMEM_AW] != '0) || (size == SZ_ILL) || w_misalign;

endmodule

// File: rtl/scdatamem.sv
// Big-endian byte-addressed data memory: combinational read with size/sign extraction,
// word/half/byte write on the falling clock edge.
module scdatamem
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [1:0]         wbh,
  input  logic               wbh_fh,
  input  logic [DMEM_AW-1:0] addr,
  input  logic [31:0]        datain,
  output logic [31:0]        dataout
);

  logic [31:0] r_mem [0:(1<<(DMEM_AW-2))-1];
  logic [31:0] w_word;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_word = r_mem[addr[DMEM_AW-1:2]];
  assign w_half = addr[1] ? w_word[15:0] : w_word[31:16];

  always_comb begin
    w_byte = w_word[31:24];
    case (addr[1:0])
      2'b01:   w_byte = w_word[23:16];
      2'b10:   w_byte = w_word[15:8];
      2'b11:   w_byte = w_word[7:0];
      default: w_byte = w_word[31:24];
    endcase
  end

  always_comb begin
    dataout = w_word;
    case (wbh)
      SZ_HALF: dataout = {{16{wbh_fh & w_half[15]}}, w_half};
      SZ_BYTE: dataout = {{24{wbh_fh & w_byte[7]}}, w_byte};
      default: dataout = w_word;
    endcase
  end

  always_ff @(negedge clk) begin
    if (we) begin
      case (wbh)
        SZ_WORD: r_mem[addr[DMEM_AW-1:2]] <= datain;
        SZ_HALF: begin
          if (addr[1]) r_mem[addr[DMEM_AW-1:2]][15:0]  <= datain[15:0];
          else         r_mem[addr[DMEM_AW-1:2]][31:16] <= datain[15:0];
        end
        SZ_BYTE: begin
          case (addr[1:0])
            2'b00:   r_mem[addr[DMEM_AW-1:2]][31:24] <= datain[7:0];
            2'b01:   r_mem[addr[DMEM_AW-1:2]][23:16] <= datain[7:0];
            2'b10:   r_mem[addr[DMEM_AW-1:2]][15:8]  <= datain[7:0];
            default: r_mem[addr[DMEM_AW-1:2]][7:0]   <= datain[7:0];
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: IDLE -> ACCESS -> RESP (errors skip ACCESS); done 2 cycles after
// accept, 1 on error; ready only in IDLE, no queuing. Alignment check via LSU_ALIGN_CHECK_EN.
module lsu_ctrl
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               we,
  input  logic [1:0]         size,
  input  logic               sign,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               ready,
  output logic               done,
  output logic [31:0]        rdata,
  output logic               addr_err,
  output logic               mem_wena,
  output logic [1:0]         mem_wbh,
  output logic               mem_wbh_fh,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_we;
  logic [DMEM_AW-1:0] r_mem_addr;
  logic [1:0]         r_mem_wbh;
  logic               r_mem_wbh_fh;
  logic [31:0]        r_mem_wdata;
  logic [31:0]        r_rdata;
  logic               r_addr_err;
  logic               w_err;
  logic               w_acc;

  lsu_addr_chk u_addr_chk (
    .addr (addr),
    .size (size),
    .err  (w_err)
  );

  assign w_acc = req && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req) w_state_nxt = w_err ? RESP : ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    done     = 1'b0;
    mem_wena = 1'b0;
    case (r_state)
      IDLE:    ready    = 1'b1;
      ACCESS:  mem_wena = r_we;
      RESP:    done     = 1'b1;
      default: ;
    endcase
  end

  // Memory-side fields load only for accesses that will actually reach memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we         <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wbh    <= '0;
      r_mem_wbh_fh <= 1'b0;
      r_mem_wdata  <= '0;
      r_rdata      <= '0;
      r_addr_err   <= 1'b0;
    end else begin
      if (w_acc && !w_err) begin
        r_we         <= we;
        r_mem_addr   <= addr[DMEM_AW-1:0];
        r_mem_wbh    <= size;
        r_mem_wbh_fh <= sign;
        r_mem_wdata  <= wdata;
      end
      if (w_acc && w_err) begin
        r_rdata    <= '0;
        r_addr_err <= 1'b1;
      end else if (r_state == ACCESS) begin
        r_rdata    <= r_we ? 32'h0 : mem_rdata;
        r_addr_err <= 1'b0;
      end
    end
  end

  assign rdata      = r_rdata;
  assign addr_err   = r_addr_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wbh    = r_mem_wbh;
  assign mem_wbh_fh = r_mem_wbh_fh;
  assign mem_wdata  = r_mem_wdata;

endmodule
